// File: rtl/muldiv_if.sv
// Request/response bundle between execute and the iterative multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [XLEN-1:0]  rs1_value;
  logic [XLEN-1:0]  rs2_value;
  logic [TAG_W-1:0] in_RegDest;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] out_RegDest;
  logic             busy;

  modport master (
    output in_valid, op, rs1_value, rs2_value, in_RegDest, flush, out_ready,
    input  in_ready, out_valid, result, out_RegDest, busy
  );

  modport slave (
    input  in_valid, op, rs1_value, rs2_value, in_RegDest, flush, out_ready,
    output in_ready, out_valid, result, out_RegDest, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on magnitudes.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        op_reg, op_next;
  logic [2*XLEN-1:0] acc_reg, acc_next;
  logic [XLEN-1:0]   opa_reg, opa_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              negq_reg, negq_next;
  logic              negr_reg, negr_next;
  logic [XLEN-1:0]   result_reg, result_next;
  logic [TAG_W-1:0]  tag_reg, tag_next;

  // Operand decode at accept time
  logic            accept;
  logic            sgn1_op, sgn2_op, s1, s2;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_result;

  assign accept   = (state_reg == IDLE) && bus.in_valid && !bus.flush;
  assign sgn1_op  = (bus.op != 3'b011) && (bus.op != 3'b101) && (bus.op != 3'b111);
  assign sgn2_op  = sgn1_op && (bus.op != 3'b010);
  assign s1       = sgn1_op && bus.rs1_value[XLEN-1];
  assign s2       = sgn2_op && bus.rs2_value[XLEN-1];
  assign mag1     = s1 ? (-bus.rs1_value) : bus.rs1_value;
  assign mag2     = s2 ? (-bus.rs2_value) : bus.rs2_value;
  assign div_zero = (bus.rs2_value == '0);
  assign div_ovf  = !bus.op[0] && (bus.rs1_value == MIN_NEG) && (bus.rs2_value == '1);

  // op[1] selects the remainder flavour of the divide ops
  always_comb begin
    special_result = '0;
    if (div_zero)
      special_result = bus.op[1] ? bus.rs1_value : '1;
    else
      special_result = bus.op[1] ? '0 : bus.rs1_value;
  end

  // One shift-add step: low half holds the remaining multiplier bits
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step, mul_prod;
  logic [XLEN-1:0]   mul_result;

  assign mul_sum    = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opa_reg} : '0);
  assign mul_step   = {mul_sum, acc_reg[XLEN-1:1]};
  assign mul_prod   = negq_reg ? (-mul_step) : mul_step;
  assign mul_result = (op_reg == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

  // One restoring step: high half is the partial remainder, low half shifts dividend into quotient
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_step;
  logic [XLEN-1:0]   quo, rem, div_result;

  assign div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opa_reg};
  assign div_step  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  acc_reg[XLEN-2:0], 1'b1};
  assign quo        = div_step[XLEN-1:0];
  assign rem        = div_step[2*XLEN-1:XLEN];
  assign div_result = op_reg[1] ? (negr_reg ? (-rem) : rem)
                                : (negq_reg ? (-quo) : quo);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_mag, fast_prod;
  logic [XLEN-1:0]   fast_result;

  assign fast_mag    = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
  assign fast_prod   = (s1 ^ s2) ? (-fast_mag) : fast_mag;
  assign fast_result = (bus.op[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    acc_next    = acc_reg;
    opa_next    = opa_reg;
    cnt_next    = cnt_reg;
    negq_next   = negq_reg;
    negr_next   = negr_reg;
    result_next = result_reg;
    tag_next    = tag_reg;

    if (bus.flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_next   = bus.op[1:0];
            tag_next  = bus.in_RegDest;
            negq_next = s1 ^ s2;
            negr_next = s1;
            cnt_next  = '0;
            if (!bus.op[2]) begin
`ifdef MULDIV_FAST_MUL_EN
              result_next = fast_result;
              state_next  = DONE;
`else
              acc_next   = {{XLEN{1'b0}}, mag2};
              opa_next   = mag1;
              state_next = MUL;
`endif
            end else if (div_zero || div_ovf) begin
              result_next = special_result;
              state_next  = DONE;
            end else begin
              acc_next   = {{XLEN{1'b0}}, mag1};
              opa_next   = mag2;
              state_next = DIV;
            end
          end
        end
        MUL: begin
          acc_next = mul_step;
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(XLEN-1)) begin
            result_next = mul_result;
            state_next  = DONE;
          end
        end
        DIV: begin
          acc_next = div_step;
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(XLEN-1)) begin
            result_next = div_result;
            state_next  = DONE;
          end
        end
        DONE: begin
          if (bus.out_ready)
            state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      acc_reg    <= '0;
      opa_reg    <= '0;
      cnt_reg    <= '0;
      negq_reg   <= 1'b0;
      negr_reg   <= 1'b0;
      result_reg <= '0;
      tag_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      acc_reg    <= acc_next;
      opa_reg    <= opa_next;
      cnt_reg    <= cnt_next;
      negq_reg   <= negq_next;
      negr_reg   <= negr_next;
      result_reg <= result_next;
      tag_reg    <= tag_next;
    end
  end

  assign bus.in_ready    = (state_reg == IDLE);
  assign bus.busy        = (state_reg != IDLE);
  assign bus.out_valid   = (state_reg == DONE);
  assign bus.result      = result_reg;
  assign bus.out_RegDest = tag_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic vectors, special cases, backpressure, flush, reset.
module tb_muldiv_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  muldiv_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag);
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.op         = op;
    bus.rs1_value  = a;
    bus.rs2_value  = b;
    bus.in_RegDest = tag;
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.rs1_value  = 32'h5A5A_5A5A;
    bus.rs2_value  = 32'hA5A5_A5A5;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    start_op(op, a, b, tag);
    wait_done(lat);
    $display("op %s a=%h b=%h -> result=%h tag=%0d latency=%0d", name, a, b, bus.result,
             bus.out_RegDest, lat);
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({name, "_res"}, bus.result, exp);
    chk({name, "_tag"}, 32'(bus.out_RegDest), 32'(tag));
    drain();
    chk({name, "_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int          lat;
    logic        seen;
    logic        stable;
    logic [31:0] held;

    bus.in_valid   = 1'b0;
    bus.op         = 3'b000;
    bus.rs1_value  = '0;
    bus.rs2_value  = '0;
    bus.in_RegDest = '0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b0;

    #12;
    chk("rst_in_ready",  32'(bus.in_ready),    32'd1);
    chk("rst_out_valid", 32'(bus.out_valid),   32'd0);
    chk("rst_busy",      32'(bus.busy),        32'd0);
    chk("rst_result",    bus.result,           32'd0);
    chk("rst_tag",       32'(bus.out_RegDest), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op("mul",    3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, MUL_LAT);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, MUL_LAT);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, MUL_LAT);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFF, MUL_LAT);
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, DIV_LAT);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, DIV_LAT);
    run_op("divu",   3'b101, 32'd100,       32'd7,         5'd12, 32'd14,        DIV_LAT);
    run_op("remu",   3'b111, 32'd100,       32'd7,         5'd13, 32'd2,         DIV_LAT);
    run_op("divu0",  3'b101, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 1);
    run_op("rem0",   3'b110, 32'd5,         32'd0,         5'd15, 32'd5,         1);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         1);

    // Backpressure: result held in DONE while out_ready stays low
    start_op(3'b101, 32'd100, 32'd7, 5'd9);
    wait_done(lat);
    held   = bus.result;
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.result !== 32'd14 || bus.out_RegDest !== 5'd9 || bus.out_valid !== 1'b1)
        stable = 1'b0;
    end
    $display("backpressure result=%h tag=%0d stable=%0b", bus.result, bus.out_RegDest, stable);
    chk("bp_result",   held,                 32'd14);
    chk("bp_stable",   32'(stable),          32'd1);
    chk("bp_in_ready", 32'(bus.in_ready),    32'd0);
    drain();
    chk("bp_release_ready", 32'(bus.in_ready),  32'd1);
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);

    // Flush with a pending request in IDLE must not accept it
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.flush     = 1'b1;
    bus.op        = 3'b100;
    bus.rs1_value = 32'd50;
    bus.rs2_value = 32'd5;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    $display("flush+in_valid in IDLE busy=%0b", bus.busy);
    chk("flush_idle_busy", 32'(bus.busy), 32'd0);

    // Flush 10 cycles into a divide
    start_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    $display("flush mid-div busy=%0b out_valid=%0b", bus.busy, bus.out_valid);
    chk("flush_busy",  32'(bus.busy),      32'd0);
    chk("flush_ready", 32'(bus.in_ready),  32'd1);
    @(negedge clk);
    bus.flush = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("flush_no_valid", 32'(seen), 32'd0);
    run_op("post_flush", 3'b000, 32'd3, 32'd4, 5'd2, 32'd12, MUL_LAT);

    // Asynchronous reset in the middle of a multiply
    start_op(3'b001, 32'h1234_5678, 32'h0000_0100, 5'd21);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    $display("reset mid-op busy=%0b valid=%0b result=%h tag=%0d", bus.busy, bus.out_valid,
             bus.result, bus.out_RegDest);
    chk("arst_busy",   32'(bus.busy),        32'd0);
    chk("arst_valid",  32'(bus.out_valid),   32'd0);
    chk("arst_result", bus.result,           32'd0);
    chk("arst_tag",    32'(bus.out_RegDest), 32'd0);
    chk("arst_ready",  32'(bus.in_ready),    32'd1);
    @(negedge clk);
    rst = 1'b1;
    run_op("post_reset", 3'b111, 32'hFFFF_FFF9, 32'd10, 5'd30, 32'd9, DIV_LAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M-style multiply/divide coprocessor, parametrised in operand width.
- Sits beside the execute stage and is fed from decode/execute register values.
- Multi-cycle ops run behind a valid/ready handshake, so execute stalls on in_ready/out_valid.
- Carries the destination register tag through to writeback; supports pipeline flush.

Parameters:
XLEN, 32, operand/result width in bits (>= 8, even)
TAG_W, 5, width of destination register tag

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low
in_valid  input  1  operation request
in_ready  output  1  unit can accept a request (high only in IDLE)
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_value  input  XLEN  dividend / multiplicand
rs2_value  input  XLEN  divisor / multiplier
in_RegDest  input  TAG_W  destination tag
flush  input  1  abort current op
out_valid  output  1  result available
out_ready  input  1  consumer takes result
result  output  XLEN  result value
out_RegDest  output  TAG_W  tag of result
busy  output  1  state != IDLE

Behaviour:
- Reset (rst low, async): state IDLE, out_valid=0, result=0, out_RegDest=0, busy=0; in_ready=1 (combinational from IDLE).
- States: IDLE, MUL, DIV, DONE.
- Accept: on a clk edge with in_valid & in_ready & !flush, latch op, operand magnitudes, sign flags and tag.
  - Mul op -> MUL; div/rem op -> DIV, unless a special case applies, in which case go directly to DONE.
- MUL: shift-add over a 2*XLEN accumulator, one bit per cycle, XLEN cycles, then DONE.
  - MULH/MULHSU/MULHU: sign-correct the magnitude product (negate if the signs differ), then take the upper XLEN bits.
  - MUL: take the lower XLEN bits.
  - rs2 is unsigned for MULHSU; both operands are unsigned for MULHU.
- DIV: restoring radix-2 on magnitudes, XLEN cycles, then DONE.
  - Quotient sign = sign(rs1) xor sign(rs2).
  - Remainder sign = sign(rs1).
- Special cases, latched in the same accept edge; out_valid goes high 1 cycle after accept:
  - Divisor 0: quotient = all ones; remainder = rs1.
  - Signed overflow (DIV/REM, rs1 = 1 followed by XLEN-1 zeros, rs2 = all ones): quotient = rs1; remainder = 0.
- Latency: out_valid goes high XLEN+1 cycles after the accept edge (iterative path), or 1 cycle after it (special cases).
- DONE:
  - out_valid=1; result and out_RegDest are stable until the handshake.
  - On out_valid & out_ready -> IDLE.
  - No accept in the same cycle: in_ready returns the next cycle, so back-to-back ops cost 1 bubble.
- flush:
  - From any state -> IDLE at the next edge; out_valid=0 from that edge; the result is discarded.
  - Priority: flush > output handshake > accept.
  - flush together with in_valid in IDLE: the request is not accepted.
- in_valid while busy: ignored; the requester holds it.
- op/operand changes after accept have no effect.
- Reset mid-operation: immediate return to IDLE with reset values; no partial result is emitted.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - Mul ops use a single combinational 2*XLEN multiplier and go from accept directly to DONE, so out_valid comes 1 cycle after accept.
  - MUL state is unused.
  - Div path is unchanged.
- Undefined: the iterative shift-add path described above (XLEN+1 cycle latency); no multiplier is inferred.

Test Plan:
- MUL, rs1=7, rs2=0xFFFFFFFD (-3), tag 5, XLEN=32 -> result 0xFFFFFFEB, out_RegDest 5; out_valid 33 cycles after accept (1 cycle with MULDIV_FAST_MUL_EN).
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2; each takes 33 cycles.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5%0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; each out_valid 1 cycle after accept.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> result/out_RegDest stable, in_ready=0. Raise out_ready -> IDLE next cycle, in_ready=1.
- Assert flush 10 cycles into a DIV -> IDLE next edge, no out_valid. Separately, pull rst low mid-MUL -> outputs zero immediately. A new op after either completes correctly.
